// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU command sequencer slice: operand/tag widths,
// FIFO geometry, ALU op encodings, the sequencer FSM state type and the
// buffered command record.
// No ports (package).
// -----------------------------------------------------------------------------
package alu_pkg;

    localparam int ALU_W      = 8;
    localparam int TAG_W      = 4;
    localparam int FIFO_DEPTH = 4;
    localparam int PTR_W      = 2;   // log2(FIFO_DEPTH); pointers wrap 3 -> 0
    localparam int CNT_W      = 3;   // holds 0..FIFO_DEPTH

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_AND = 2'b10,
        ALU_OR  = 2'b11
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_OUT     = 2'd3
    } seq_state_e;

    typedef struct packed {
        logic [ALU_W-1:0] a;
        logic [ALU_W-1:0] b;
        alu_op_e          sel;
        logic [TAG_W-1:0] tag;
    } alu_cmd_t;

endpackage

// File: rtl/alu_cmd_fifo.sv
// -----------------------------------------------------------------------------
// alu_cmd_fifo
// 4-entry command FIFO. Registered read path (no bypass): an entry written on
// one edge becomes visible at the head only after that edge.
// Ports:
//   clk      in   clock, rising edge
//   rst      in   asynchronous active-low reset (clears pointers and count)
//   push_i   in   write wdata_i at the tail (ignored when full)
//   pop_i    in   drop the head entry (ignored when empty)
//   wdata_i  in   command to enqueue
//   rdata_o  out  head command
//   full_o   out  count == FIFO_DEPTH
//   empty_o  out  count == 0
//   count_o  out  entries held (0..FIFO_DEPTH)
// -----------------------------------------------------------------------------
module alu_cmd_fifo
    import alu_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic             pop_i,
    input  alu_cmd_t         wdata_i,
    output alu_cmd_t         rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);

    alu_cmd_t         mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok;
    logic             pop_ok;

    assign full_o  = (count_q == CNT_W'(FIFO_DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        // Pointers are PTR_W wide so the increment wraps 3 -> 0 naturally.
        if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
        // Simultaneous push and pop leaves the count unchanged.
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset: validity is carried entirely by the count.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// alu_cmd_sequencer
// Buffers {a,b,sel,tag} commands in a 4-deep FIFO and issues them one at a
// time to a downstream registered ALU, capturing result, carry and tag and
// presenting them on a valid/ready output port. Commands complete in order.
// Ports:
//   clk, rst                 clock / asynchronous active-low reset
//   in_valid, in_ready       command handshake (in_ready = FIFO not full)
//   in_a, in_b, in_sel, in_tag  command fields
//   alu_a, alu_b, alu_sel    registered operands/op to the ALU
//   alu_y, alu_c             registered ALU result/carry
//   out_valid, out_ready     result handshake
//   out_y, out_c, out_tag    captured result, carry, tag
//   fifo_count               entries currently buffered (0..4)
// -----------------------------------------------------------------------------
module alu_cmd_sequencer
    import alu_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [ALU_W-1:0] in_a,
    input  logic [ALU_W-1:0] in_b,
    input  logic [1:0]       in_sel,
    input  logic [TAG_W-1:0] in_tag,
    output logic [ALU_W-1:0] alu_a,
    output logic [ALU_W-1:0] alu_b,
    output logic [1:0]       alu_sel,
    input  logic [ALU_W-1:0] alu_y,
    input  logic             alu_c,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ALU_W-1:0] out_y,
    output logic             out_c,
    output logic [TAG_W-1:0] out_tag,
    output logic [CNT_W-1:0] fifo_count
);

    alu_cmd_t   in_cmd;
    alu_cmd_t   head_cmd;
    logic       fifo_full;
    logic       fifo_empty;
    logic       fifo_push;
    logic       fifo_pop;
    logic       capture;

    seq_state_e state_q, state_d;

    logic [ALU_W-1:0] alu_a_q, alu_a_d;
    logic [ALU_W-1:0] alu_b_q, alu_b_d;
    alu_op_e          alu_sel_q, alu_sel_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic [ALU_W-1:0] out_y_q, out_y_d;
    logic             out_c_q, out_c_d;
    logic [TAG_W-1:0] out_tag_q, out_tag_d;

    assign in_cmd = '{a: in_a, b: in_b, sel: alu_op_e'(in_sel), tag: in_tag};

    // Depends on the count only, so a producer may wait on in_ready before
    // raising in_valid.
    assign in_ready  = !fifo_full;
    assign fifo_push = in_valid && in_ready;

    alu_cmd_fifo u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .wdata_i (in_cmd),
        .rdata_o (head_cmd),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // ---- FSM: state register ----
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= ST_IDLE;
        else      state_q <= state_d;
    end

    // ---- FSM: next state ----
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (!fifo_empty) state_d = ST_ISSUE;
            ST_ISSUE:   state_d = ST_CAPTURE;
            ST_CAPTURE: state_d = ST_OUT;
            ST_OUT: begin
                // Chain straight into the next command to keep 3 cycles/result.
                if (out_ready) state_d = fifo_empty ? ST_IDLE : ST_ISSUE;
            end
            default:    state_d = ST_IDLE;
        endcase
    end

    // ---- FSM: outputs ----
    always_comb begin
        fifo_pop  = 1'b0;
        capture   = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            ST_IDLE:    fifo_pop = !fifo_empty;
            ST_CAPTURE: capture  = 1'b1;
            ST_OUT: begin
                out_valid = 1'b1;
                fifo_pop  = out_ready && !fifo_empty;
            end
            default: ;
        endcase
    end

    // Operands load only on a pop, so they hold the last issued command
    // everywhere outside ISSUE. Results load only in CAPTURE, so they stay
    // frozen throughout a stalled OUT.
    always_comb begin
        alu_a_d   = alu_a_q;
        alu_b_d   = alu_b_q;
        alu_sel_d = alu_sel_q;
        tag_d     = tag_q;
        out_y_d   = out_y_q;
        out_c_d   = out_c_q;
        out_tag_d = out_tag_q;
        if (fifo_pop) begin
            alu_a_d   = head_cmd.a;
            alu_b_d   = head_cmd.b;
            alu_sel_d = head_cmd.sel;
            tag_d     = head_cmd.tag;
        end
        if (capture) begin
            out_y_d   = alu_y;
            out_c_d   = alu_c;
            out_tag_d = tag_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            alu_a_q   <= '0;
            alu_b_q   <= '0;
            alu_sel_q <= ALU_ADD;
            tag_q     <= '0;
            out_y_q   <= '0;
            out_c_q   <= 1'b0;
            out_tag_q <= '0;
        end else begin
            alu_a_q   <= alu_a_d;
            alu_b_q   <= alu_b_d;
            alu_sel_q <= alu_sel_d;
            tag_q     <= tag_d;
            out_y_q   <= out_y_d;
            out_c_q   <= out_c_d;
            out_tag_q <= out_tag_d;
        end
    end

    assign alu_a   = alu_a_q;
    assign alu_b   = alu_b_q;
    assign alu_sel = alu_sel_q;
    assign out_y   = out_y_q;
    assign out_c   = out_c_q;
    assign out_tag = out_tag_q;

endmodule

// File: doc/alu_cmd_sequencer.md
ALU_CMD_SEQUENCER -- requirements
Module: alu_cmd_sequencer

Interface
REQ-001 SHALL have ports (name  direction  width  meaning):
- clk  in  1  clock, all state on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- in_valid  in  1  command valid.
- in_ready  out  1  command FIFO can accept.
- in_a / in_b  in  8  operands.
- in_sel  in  2  op: 00 add, 01 sub, 10 and, 11 or.
- in_tag  in  4  caller tag, returned with result.
- alu_a / alu_b  out  8  registered operands to downstream ALU.
- alu_sel  out  2  registered op to ALU.
- alu_y  in  8  ALU registered result.
- alu_c  in  1  ALU registered carry.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_y / out_c / out_tag  out  8/1/4  captured result, carry, tag.
- fifo_count  out  3  entries buffered (0..4).

Function
REQ-002 SHALL buffer commands {a,b,sel,tag} in a 4-entry FIFO; push on rising edge when in_valid && in_ready.
REQ-003 SHALL drive in_ready = (fifo_count != 4), combinational from count only, no dependence on in_valid.
REQ-004 SHALL NOT bypass the FIFO; a command pushed at edge e is poppable no earlier than edge e+1.
REQ-005 SHALL run FSM states IDLE, ISSUE, CAPTURE, OUT.
REQ-006 IDLE: if FIFO non-empty, pop head, load alu_a/alu_b/alu_sel and tag register, go ISSUE; else stay.
REQ-007 ISSUE: operands held stable one cycle (ALU samples them at the edge ending ISSUE); go CAPTURE.
REQ-008 CAPTURE: load out_y <= alu_y, out_c <= alu_c, out_tag <= tag register; go OUT.
REQ-009 OUT: out_valid = 1; out_y/out_c/out_tag SHALL stay constant until out_valid && out_ready.
REQ-010 On the OUT handshake edge: if FIFO non-empty, pop and go ISSUE directly; else go IDLE.
REQ-011 out_valid SHALL be 1 only in OUT.
REQ-012 Latency: push into empty FIFO at edge e, idle FSM -> out_valid high after edge e+3.
REQ-013 Sustained throughput with out_ready held high: one result per 3 cycles.
REQ-014 Push and pop on the same edge SHALL both take effect; count unchanged.
REQ-015 FIFO pointers SHALL be 2-bit, wrapping 3->0; push when full is impossible because in_ready is low.
REQ-016 Commands SHALL complete in strict acceptance order; no command dropped or duplicated.
REQ-017 alu_a/alu_b/alu_sel SHALL hold their last issued value outside ISSUE.

Reset
REQ-018 rst low SHALL immediately clear FIFO (count 0, pointers 0), state IDLE, and zero all outputs: alu_a, alu_b, alu_sel, out_y, out_c, out_tag, out_valid.
REQ-019 Reset mid-operation SHALL discard buffered and in-flight commands, with no result emitted for them after release.
REQ-020 in_ready SHALL be 1 during and after reset, since count is 0.

Structure
REQ-021 Shared package alu_pkg SHALL hold:
- op encodings ALU_ADD/SUB/AND/OR;
- FSM state enum;
- ALU_W=8, TAG_W=4, FIFO_DEPTH=4.
REQ-022 FIFO SHALL be sub-module alu_cmd_fifo (push/pop/full/empty/count); the FSM and capture logic stay in the top level.

Verification
REQ-023 The bench SHALL instantiate the sequencer with the 8-bit ALU downstream and cover:
- Add: a=F0, b=20, sel=00, tag=3 -> out_y=10, out_c=1, out_tag=3, out_valid rises 3 cycles after push.
- Sub: a=05, b=03, sel=01 -> out_y=02, out_c=1; a=03, b=05 -> out_y=FE, out_c=0.
- Logic: a=F0, b=3C; sel=10 -> out_y=30, out_c=0; sel=11 -> out_y=FC, out_c=0.
- Backpressure: out_ready=0, push 6 commands tags 0..5 -> 5 accepted, in_ready low on 6th, count=4; release out_ready -> tags 0..4 in order, outputs stable while stalled.
- Reset mid-operation: 3 commands queued, assert rst in CAPTURE -> outputs 0 immediately, count=0; after release no stale result appears.
- Back-to-back push/pop at count=2 with out_ready=1 -> count stays 2 that cycle, order preserved.
